i2s_sample_tx: RTL

- Consumer end of the mono sample stream (16-bit signed sample plus single-cycle valid strobe) produced by the effect chain.
- Serializes each sample onto a standard Philips I2S link (BCLK, LRCLK, SDATA) for the board DAC.
- The mono sample is duplicated to the left and right channels.
- Paces the upstream producer with a per-frame request pulse, and flags underrun and overrun.

---
 rtl/i2s_sample_tx.sv | 99 +++++++++
 1 files changed

// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx: serializes a mono 16-bit sample stream onto a Philips I2S link.
// The same word is sent on the left and right channels. The producer is paced by a
// per-frame request pulse. Underrun and overrun are reported as single-cycle pulses.
module i2s_sample_tx #(
   parameter int unsigned BCLK_DIV = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [15:0] sample_in,
   input  logic               sample_in_valid,
   output logic               sample_req,
   output logic               underrun,
   output logic               overrun,
   output logic               i2s_bclk,
   output logic               i2s_lrclk,
   output logic               i2s_sdata
);

   localparam int unsigned DIV_W  = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
   localparam int unsigned SLOT_W = 5;
   localparam int unsigned WORD_W = 16;

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCLK_DIV - 1);
   localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(BCLK_DIV / 2);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(31);
   localparam logic [SLOT_W-1:0] LR_FIRST  = SLOT_W'(15);
   localparam logic [SLOT_W-1:0] LR_LAST   = SLOT_W'(30);

   logic [DIV_W-1:0]  div_cnt;
   logic [DIV_W-1:0]  div_nxt;
   logic [SLOT_W-1:0] slot;
   logic [SLOT_W-1:0] slot_nxt;
   logic [WORD_W-1:0] pending;
   logic              pending_fresh;
   logic [WORD_W-1:0] tx_word;
   logic [WORD_W-1:0] word_nxt;
   logic              div_wrap;
   logic              load;
   logic [3:0]        bit_idx_nxt;

   // Next counter values and the word that will be on the wire after this edge
   always_comb begin
      div_wrap    = (div_cnt == DIV_LAST);
      load        = div_wrap && (slot == SLOT_LAST);
      div_nxt     = div_wrap ? '0 : div_cnt + DIV_W'(1);
      slot_nxt    = div_wrap ? slot + SLOT_W'(1) : slot;
      word_nxt    = tx_word;
      if (load) begin
         word_nxt = sample_in_valid ? WORD_W'(sample_in) : pending;
      end
      bit_idx_nxt = 4'd15 - slot_nxt[3:0];
   end

   // Bit-clock divider and slot counter
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
         slot    <= '0;
      end else begin
         div_cnt <= div_nxt;
         slot    <= slot_nxt;
      end
   end

   // Pending sample holding register, frame word and flow-control pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         pending       <= '0;
         pending_fresh <= 1'b0;
         tx_word       <= '0;
         sample_req    <= 1'b0;
         underrun      <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         if (sample_in_valid) begin
            pending <= WORD_W'(sample_in);
         end
         pending_fresh <= load ? 1'b0 : (pending_fresh | sample_in_valid);
         tx_word       <= word_nxt;
         sample_req    <= load;
         underrun      <= load && !sample_in_valid && !pending_fresh;
         overrun       <= sample_in_valid && pending_fresh && !load;
      end
   end

   // Registered I2S pins, computed from the counter values being entered
   always_ff @(posedge clk) begin
      if (rst) begin
         i2s_bclk  <= 1'b0;
         i2s_lrclk <= 1'b0;
         i2s_sdata <= 1'b0;
      end else begin
         i2s_bclk  <= (div_nxt >= DIV_HALF);
         i2s_lrclk <= (slot_nxt >= LR_FIRST) && (slot_nxt <= LR_LAST);
         i2s_sdata <= word_nxt[bit_idx_nxt];
      end
   end

endmodule
